// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares the single text-mode VRAM port between video fetch, CPU bus and clear engine.
// Fixed priority video > CPU > clear; three-stage arbitrate/issue/return pipeline steered by a delayed tag.
module vga_vram_arbiter #(
   parameter int DEPTH = 2400,
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          pixel_clk,
   input  logic          data_reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_value,
   output logic          clr_busy,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   typedef enum logic [2:0] {T_NONE, T_VID, T_VIDNULL, T_CPU, T_CPUNULL, T_CLR} tag_t;
   tag_t tag_arb, tag_iss, tag_ret;
   logic cpu_busy, cpu_grant, clr_go, nxt_we;
   logic [AW-1:0] clr_cnt, nxt_addr;
   logic [DW-1:0] clr_val, nxt_wdata, cpu_hold;
   // a restart pulse suppresses the clear slot so the fill always begins at address 0
   always_comb begin
      cpu_grant = !vid_req && cpu_req && !cpu_busy;
      clr_go = !vid_req && !cpu_grant && clr_busy && !clr_start;
      tag_arb = vid_req ? (vid_addr <= LAST ? T_VID : T_VIDNULL) :
                cpu_grant ? (cpu_addr <= LAST ? T_CPU : T_CPUNULL) :
                clr_go ? T_CLR : T_NONE;
      nxt_addr = tag_arb == T_VID ? vid_addr : tag_arb == T_CPU ? cpu_addr :
                 tag_arb == T_CLR ? clr_cnt : '0;
      nxt_we = tag_arb == T_CLR || (tag_arb == T_CPU && cpu_we);
      nxt_wdata = tag_arb == T_CLR ? clr_val : nxt_we ? cpu_wdata : '0;
   end
   assign vid_valid = tag_ret == T_VID || tag_ret == T_VIDNULL;
   assign vid_data = tag_ret == T_VID ? ram_rdata : '0;
   assign cpu_ack = tag_ret == T_CPU || tag_ret == T_CPUNULL;
   assign cpu_rdata = tag_ret == T_CPU ? ram_rdata : tag_ret == T_CPUNULL ? '0 : cpu_hold;
   always_ff @(posedge pixel_clk) begin
      if (data_reset) begin
         ram_addr <= '0;
         ram_wdata <= '0;
         ram_we <= 1'b0;
         tag_iss <= T_NONE;
         tag_ret <= T_NONE;
         cpu_hold <= '0;
         cpu_busy <= 1'b0;
         clr_busy <= 1'b0;
         clr_cnt <= '0;
         clr_val <= '0;
      end else begin
         ram_addr <= nxt_addr;
         ram_wdata <= nxt_wdata;
         ram_we <= nxt_we;
         tag_iss <= tag_arb;
         tag_ret <= tag_iss;
         cpu_hold <= cpu_rdata;
         if (cpu_grant) cpu_busy <= 1'b1;
         else if (cpu_ack) cpu_busy <= 1'b0;
         if (clr_start) begin
            clr_busy <= 1'b1;
            clr_cnt <= '0;
            clr_val <= clr_value;
         end else if (clr_go) begin
            if (clr_cnt == LAST) clr_busy <= 1'b0;
            else clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end
endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Owns the single port of the text-mode video RAM: 16-bit cells, with attribute in [15:8] and character code in [7:0].
- Shares that port between three requesters, in fixed priority order:
  - the pixel-generator character fetch (real-time, highest);
  - the CPU bus (read/write);
  - a built-in clear-screen engine that fills the buffer with one value.
- Sits between the VGA pixel path, the CPU bus bridge and the video RAM instance.

Parameters:
- DEPTH, 2400: number of valid cells (80 cols x 30 rows); addresses 0..DEPTH-1.
- AW, 12: address width.
- DW, 16: cell width.

Ports:
- pixel_clk  in  1  sole clock.
- data_reset  in  1  synchronous, active-high reset.
- vid_req  in  1  single-cycle video fetch request.
- vid_addr  in  AW  video fetch address.
- vid_data  out  DW  fetched cell.
- vid_valid  out  1  vid_data valid pulse.
- cpu_req  in  1  CPU access request (level, held until cpu_ack).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  access complete pulse.
- clr_start  in  1  start clear pulse.
- clr_value  in  DW  fill value, sampled at clr_start.
- clr_busy  out  1  clear in progress.
- ram_addr  out  AW  RAM address (registered).
- ram_wdata  out  DW  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_addr is presented.

Behaviour:
- Reset
  - One cycle of data_reset: all outputs 0; CPU pending flag cleared; clear engine aborted (counter 0); pipeline tags set to NONE.
  - Reset mid-clear or mid-CPU access drops the operation; no ack is issued.
- Pipeline and arbitration
  - Cycle N (arbitrate): one winner chosen from the sampled requests.
  - Cycle N+1 (issue): ram_addr, ram_we and ram_wdata registered from the winner.
  - Cycle N+2 (return): ram_rdata is routed according to a delayed tag (NONE/VID/CPU/CPUNULL/CLR).
  - Priority: vid_req > CPU (cpu_req & !cpu_busy) > clear (clr_busy). At most one RAM access per cycle.
  - ram_we is 0 on every cycle without a CPU write or clear write.
- Video path
  - Fixed latency of 2: vid_req at N gives vid_valid=1 with vid_data=RAM[vid_addr] at N+2.
  - vid_req may be asserted on consecutive cycles; each request is served.
  - vid_addr >= DEPTH: no RAM access; vid_valid at N+2 with vid_data=0.
- CPU path
  - Granted at N gives cpu_ack=1 for exactly one cycle at N+2.
  - Read: cpu_rdata=RAM[cpu_addr] at N+2. Write: RAM is written at the N+1 edge.
  - Internal cpu_busy is set at grant and cleared after the ack cycle, so the earliest regrant is N+3.
  - cpu_req still high during the ack cycle is not regranted.
  - cpu_addr/cpu_we/cpu_wdata are captured at grant; later changes are ignored.
  - cpu_addr >= DEPTH: no RAM access; cpu_ack at N+2 with cpu_rdata=0.
  - Lost arbitration to video: CPU waits with no ack; the grant occurs on the first cycle with vid_req=0.
  - cpu_rdata holds its last value between acks.
- Clear engine
  - clr_start latches clr_value, sets counter=0 and clr_busy=1 on the next cycle.
  - Each arbitration cycle won by clear issues a write of the value to address counter, then counter increments.
  - After the grant for address DEPTH-1, clr_busy drops the next cycle.
  - clr_start while busy restarts from 0 with the new value.
  - A CPU write to an address >= counter during a clear is overwritten later. This is accepted behaviour.
  - CPU reads during a clear return the current RAM content.
- Wrap and width
  - Counters are AW bits.
  - The clear counter never exceeds DEPTH-1.
  - No address wrap is applied to requester addresses; out-of-range requests are nulled as above.

Test Plan:
- Video latency
  - Stimulus: RAM preloaded RAM[5]=16'h1E41; vid_req with vid_addr=5 at cycle 10.
  - Required: vid_valid=1 and vid_data=16'h1E41 at cycle 12; vid_valid=0 at cycles 11 and 13.
- CPU write then read
  - Stimulus: write 16'h0742 to addr 100, then read addr 100.
  - Required: ram_we=1 for exactly one cycle with ram_addr=100; read acks with cpu_rdata=16'h0742; each ack is 2 cycles after its grant.
- Collision
  - Stimulus: vid_req and cpu_req both high at cycle 20; vid_req also high at cycle 21.
  - Required: video served at 20 and 21; CPU granted at 22 and acked at 24.
- Clear
  - Stimulus: clr_start with clr_value=16'h0720 and no other traffic.
  - Required: 2400 consecutive writes to addresses 0..2399, all 16'h0720; clr_busy high for 2400 cycles, then 0.
  - Stimulus: inject vid_req every 8th cycle.
  - Required: the clear takes 2400 + (number of video slots) cycles, and no address is skipped or repeated.
- Out-of-range and reset
  - Stimulus: CPU read of addr 2400.
  - Required: ack with cpu_rdata=0 and no RAM access.
  - Stimulus: data_reset asserted mid-clear at counter=500.
  - Required: clr_busy=0 and ram_we=0 next cycle; a new clr_start then restarts at address 0.
